latch_stim_gen: RTL

Synthesizable stimulus source that sits directly upstream of the d_latch and drives its d and en inputs. It runs a fixed number of iterations. Each iteration waits a pseudo-random 0..3 cycle delay and toggles en, then waits a pseudo-random 0..7 cycle delay and toggles d. Delays come from an internal 16-bit LFSR, so sequences are repeatable from a seed, and the generator can be used on silicon/FPGA in place of a behavioural bench.

---
 rtl/latch_stim_if.sv | 14 +
 rtl/latch_stim_gen.sv | 71 +++++++
 2 files changed

// File: rtl/latch_stim_if.sv
// latch_stim_if: control and latch-drive signals of latch_stim_gen
interface latch_stim_if #(
  parameter int CW = 8
);
  logic          start;
  logic          abort;
  logic          d;
  logic          en;
  logic          busy;
  logic          done;
  logic [CW-1:0] iter_cnt;
  modport master(input start, abort, output d, en, busy, done, iter_cnt);
  modport slave(output start, abort, input d, en, busy, done, iter_cnt);
endinterface

// File: rtl/latch_stim_gen.sv
// latch_stim_gen: LFSR-timed toggle source for the d/en inputs of a d_latch
module latch_stim_gen #(
  parameter int          ITER = 5,
  parameter logic [15:0] SEED = 16'hACE1,
  parameter int          CW   = 8
) (
  input logic clk,
  input logic rst,
  latch_stim_if.master io
);
  localparam logic [15:0] SEED_NZ = (SEED == 16'h0000) ? 16'h0001 : SEED;
  typedef enum logic [1:0] {IDLE, LOAD, WAIT_EN, WAIT_D} state_t;
  state_t      state;
  logic [15:0] lfsr;
  logic [2:0]  cnt;
  logic [2:0]  dly_d;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state       <= IDLE;
      io.d        <= 1'b0;
      io.en       <= 1'b0;
      io.busy     <= 1'b0;
      io.done     <= 1'b0;
      io.iter_cnt <= '0;
      lfsr        <= SEED_NZ;
      cnt         <= 3'd0;
      dly_d       <= 3'd0;
    end else if (state != IDLE && io.abort) begin
      // abort wins over any toggle due on this edge; outputs freeze
      state   <= IDLE;
      io.busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          io.done <= 1'b0;
          if (io.start) begin
            io.busy     <= 1'b1;
            io.iter_cnt <= '0;
            state       <= LOAD;
          end
        end
        LOAD: begin
          cnt   <= {1'b0, lfsr[1:0]};
          dly_d <= lfsr[4:2];
          lfsr  <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
          state <= WAIT_EN;
        end
        WAIT_EN: begin
          if (cnt != 3'd0) cnt <= cnt - 3'd1;
          else begin
            io.en <= ~io.en;
            cnt   <= dly_d;
            state <= WAIT_D;
          end
        end
        WAIT_D: begin
          if (cnt != 3'd0) cnt <= cnt - 3'd1;
          else begin
            io.d        <= ~io.d;
            io.iter_cnt <= io.iter_cnt + CW'(1);
            if (io.iter_cnt == CW'(ITER - 1)) begin
              state   <= IDLE;
              io.busy <= 1'b0;
              io.done <= 1'b1;
            end else state <= LOAD;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule
